// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI:LO result registers.
// Latency: fixed 33 clock edges from accepted start to hi/lo update, for every op (incl. divide-by-zero).
// Backpressure: start is accepted only in IDLE; start while busy is ignored, MTHI/MTLO writes only land when idle.
//
// Ports:
//   clk            single clock, rising edge
//   rst            asynchronous active-low reset
//   start, op      begin operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b           rs / rt operands, captured when start is accepted
//   hi_we, lo_we   MTHI / MTLO write strobes, wdata is the write data
//   busy           high while an operation is in flight
//   done           one-cycle pulse when hi/lo have just been updated
//   hi, lo         architectural HI / LO registers
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        op_div;   // latched: 1 = divide, 0 = multiply
  logic        neg_q;    // negate product / quotient at the end
  logic        neg_r;    // negate remainder (dividend was negative)
  logic        div0;     // divide with zero divisor
  logic [31:0] opnd;     // multiplicand magnitude, or divisor magnitude
  logic [63:0] acc;      // working register, never visible on hi/lo

  // ---------------------------------------------------------------------
  // Operand conditioning at start: signed ops work on magnitudes.
  // ---------------------------------------------------------------------
  logic        in_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  always_comb begin
    in_signed = ~op[0];
    a_neg     = in_signed & a[31];
    b_neg     = in_signed & b[31];
    a_mag     = a_neg ? (~a + 32'd1) : a;
    b_mag     = b_neg ? (~b + 32'd1) : b;
  end

  // ---------------------------------------------------------------------
  // One multiply step: acc[31:0] starts as the multiplier and is shifted
  // out LSB first while the partial product grows into the upper half.
  // ---------------------------------------------------------------------
  logic [32:0] mul_sum;
  logic [63:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
  end

  // ---------------------------------------------------------------------
  // One restoring divide step: acc = {remainder, dividend/quotient}.
  // The 33-bit partial remainder is the old remainder with the next
  // dividend bit shifted in; quotient bits enter at acc[0].
  // ---------------------------------------------------------------------
  logic [32:0] div_rem;
  logic [33:0] div_diff;
  logic [63:0] div_next;

  always_comb begin
    div_rem  = {acc[63:32], acc[31]};
    div_diff = {1'b0, div_rem} - {2'b00, opnd};
    if (div_diff[33]) begin
      // Trial subtract went negative: restore, quotient bit 0.
      div_next = {div_rem[31:0], acc[30:0], 1'b0};
    end else begin
      // Result is below the divisor, so it always fits in 32 bits.
      div_next = {div_diff[31:0], acc[30:0], 1'b1};
    end
  end

  // ---------------------------------------------------------------------
  // Final sign correction, applied only in FIN.
  // ---------------------------------------------------------------------
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    prod_fix = neg_q ? (~acc + 64'd1) : acc;
    quo_fix  = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
    // Zero divisor: the array produces all-ones quotient bits and the
    // remainder ends up as |a|, which sign correction turns back into a.
    // Only the quotient needs forcing, since negating it would be wrong.
    if (div0) begin
      quo_fix = 32'hFFFF_FFFF;
    end
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------
  // Control FSM and all state.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      opnd   <= 32'd0;
      acc    <= 64'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // A coincident MTHI/MTLO is dropped: start takes priority.
            op_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= op[1] & a_neg;
            div0   <= op[1] & (b == 32'd0);
            opnd   <= op[1] ? b_mag : a_mag;
            acc    <= {32'd0, (op[1] ? a_mag : b_mag)};
            cnt    <= 5'd0;
            state  <= CALC;
          end else begin
            if (hi_we) begin
              hi <= wdata;
            end
            if (lo_we) begin
              lo <= wdata;
            end
          end
        end

        CALC: begin
          acc <= op_div ? div_next : mul_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= FIN;
          end
        end

        FIN: begin
          if (op_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed ops feed a scoreboard queue, a monitor
// compares hi/lo on every done pulse, and the driver checks latency, busy, MTHI/MTLO and reset.
module tb_muldiv_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [63:0] exp_q[$];

  muldiv_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected {hi,lo} and compares.
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual hi=%h lo=%h expected no done", hi, lo);
        end else begin
          e = exp_q.pop_front();
          check32("sb_hi", hi, e[63:32]);
          check32("sb_lo", lo, e[31:0]);
        end
      end
    end
  end

  // Called at a negedge; start is sampled at the following posedge (E0).
  // Returns at the negedge after E0 with the operand inputs scrambled.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back({eh, el});
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom);
    check32("busy_after_start", {31'd0, busy}, 32'd1);
    check32("done_low_after_start", {31'd0, done}, 32'd0);
  endtask

  // Waits (bounded) for done and checks how many negedges it took.
  task automatic wait_done(input int exp_lat);
    int n;
    n = 0;
    while (done !== 1'b1 && n <= 40) begin
      @(negedge clk);
      n++;
    end
    check32("latency", n, exp_lat);
  endtask

  // Full op: start, wait for done, then confirm the pulse is a single cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el);
    start_op(o, x, y, eh, el);
    wait_done(33);
    @(negedge clk);
    check32("done_one_cycle", {31'd0, done}, 32'd0);
    check32("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin : driver
    int d0;
    // Reset state.
    #12;
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_done", {31'd0, done}, 32'd0);
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // First start right at the first edge with reset released, then a
    // second start during the done-pulse cycle.
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_done(33);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    // Directed vectors.
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op(OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
    run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op(OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);
    run_op(OP_MULT,  32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    run_op(OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);

    // Start and MTHI/MTLO while busy are ignored.
    start_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
    check32("busy_mid_op", {31'd0, busy}, 32'd1);
    check32("hi_hold_mid_op", hi, 32'h0000_000F);
    wait_done(28);
    @(negedge clk);
    check32("hi_after_ignored", hi, 32'd2);
    check32("lo_after_ignored", lo, 32'd14);
    lo_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    lo_we = 1'b0;
    check32("mtlo_lo", lo, 32'h0000_1234);
    check32("mtlo_hi_untouched", hi, 32'd2);
    hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0;
    check32("mthi_hi", hi, 32'hCAFE_F00D);
    check32("mthi_lo_untouched", lo, 32'h0000_1234);

    // MTHI coinciding with start is dropped.
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    start_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);
    check32("mthi_dropped", hi, 32'hCAFE_F00D);
    wait_done(33);
    @(negedge clk);

    // Reset mid-CALC aborts the operation.
    start_op(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30);
    repeat (9) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check32("abort_busy", {31'd0, busy}, 32'd0);
    check32("abort_done", {31'd0, done}, 32'd0);
    check32("abort_hi", hi, 32'd0);
    check32("abort_lo", lo, 32'd0);
    exp_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check32("no_done_after_abort", done_cnt, d0);
    check32("idle_after_abort", {31'd0, busy}, 32'd0);
    check32("hi_kept_zero", hi, 32'd0);
    check32("lo_kept_zero", lo, 32'd0);

    run_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    check32("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
